// File: rtl/hring_boundary_sched_pkg.sv
// Shared types for the hierarchical-ring boundary slot scheduler.
// Flit width, FSM state encodings, source-select enum and a saturating-increment helper.
package hring_boundary_sched_pkg;

    localparam int unsigned CONTROL_W = 144;
    localparam int unsigned STAT_W    = 16;

    typedef logic [CONTROL_W-1:0] flit_t;

    typedef enum logic [1:0] {
        HRS_NORMAL = 2'd0,
        HRS_STARVE = 2'd1,
        HRS_DRAIN  = 2'd2
    } hrs_state_e;

    typedef enum logic [1:0] {
        SEL_NONE = 2'd0,
        SEL_RING = 2'd1,
        SEL_BUF  = 2'd2,
        SEL_INJ  = 2'd3
    } sel_e;

    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (v == '1) ? v : v + STAT_W'(1);
    endfunction

endpackage

// File: rtl/hring_boundary_sched_if.sv
// Ring / injection / boundary-slot signal bundle for hring_boundary_sched.
interface hring_boundary_sched_if;
    import hring_boundary_sched_pkg::*;

    logic  ring_valid;
    flit_t ring_flit;
    logic  inj_valid;
    flit_t inj_flit;
    logic  inj_ready;
    logic  out_valid;
    flit_t out_flit;

    modport master (
        output ring_valid, ring_flit, inj_valid, inj_flit,
        input  inj_ready, out_valid, out_flit
    );

    modport slave (
        input  ring_valid, ring_flit, inj_valid, inj_flit,
        output inj_ready, out_valid, out_flit
    );

endinterface

// File: rtl/hring_sched_fifo.sv
// Circular deflection buffer: DEPTH x W, wrap-around pointers, async active-high reset.
// Push when full and pop when empty are ignored.
module hring_sched_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 144
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [W-1:0]             i_din,
    input  logic                     i_pop,
    output logic [W-1:0]             o_head,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [W-1:0]     r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_head    = r_mem[r_rd_ptr];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    // Storage carries no reset; occupancy alone defines validity.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_din;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/hring_boundary_sched.sv
// Boundary slot scheduler: merges through-ring flits, a deflection buffer and an injection port.
// Optional saturating statistics are built when HRING_SCHED_STATS_EN is defined.
module hring_boundary_sched
    import hring_boundary_sched_pkg::*;
#(
    parameter int unsigned BUF_DEPTH  = 4,
    parameter int unsigned STARVE_MAX = 8,
    parameter int unsigned CNT_W      = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    hring_boundary_sched_if.slave       bus,
    output logic [$clog2(BUF_DEPTH):0]  o_buf_count,
    output logic [STAT_W-1:0]           o_stat_defl,
    output logic [STAT_W-1:0]           o_stat_inj
);

    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    logic             w_starving;
    logic             w_defl;
    logic             w_inj_starve;
    logic             w_inj_ready;
    logic             w_drain_pending;
    flit_t            w_buf_head;
    flit_t            w_sel_flit;
    sel_e             w_sel;
    hrs_state_e       r_state;
    hrs_state_e       w_state_nxt;
    logic [CNT_W-1:0] r_starve_cnt;
    logic             r_out_valid;
    flit_t            r_out_flit;

    hring_sched_fifo #(
        .DEPTH (BUF_DEPTH),
        .W     (CONTROL_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_din   (bus.ring_flit),
        .i_pop   (w_pop),
        .o_head  (w_buf_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (o_buf_count)
    );

    assign w_starving = bus.inj_valid && (r_starve_cnt >= CNT_W'(STARVE_MAX));

    // Priority selection; ring flits are either sent or parked, never dropped.
    always_comb begin
        w_sel        = SEL_NONE;
        w_push       = 1'b0;
        w_pop        = 1'b0;
        w_defl       = 1'b0;
        w_inj_starve = 1'b0;
        if (w_starving && bus.ring_valid && !w_full) begin
            w_sel  = SEL_INJ;
            w_push = 1'b1;
            w_defl = 1'b1;
        end else if (w_starving && !bus.ring_valid) begin
            w_sel        = SEL_INJ;
            w_inj_starve = 1'b1;
        end else if (bus.ring_valid) begin
            w_sel = SEL_RING;
        end else if (!w_empty) begin
            w_sel = SEL_BUF;
            w_pop = 1'b1;
        end else if (bus.inj_valid && !w_drain_pending) begin
            w_sel = SEL_INJ;
        end
    end

    always_comb begin
        w_sel_flit = r_out_flit;
        case (w_sel)
            SEL_RING: w_sel_flit = bus.ring_flit;
            SEL_BUF:  w_sel_flit = w_buf_head;
            SEL_INJ:  w_sel_flit = bus.inj_flit;
            default:  w_sel_flit = r_out_flit;
        endcase
    end

    assign w_inj_ready   = !rst && (w_sel == SEL_INJ);
    assign bus.inj_ready = w_inj_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_flit  = r_out_flit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_starve_cnt <= '0;
        end else if (!bus.inj_valid || w_inj_ready) begin
            r_starve_cnt <= '0;
        end else if (r_starve_cnt != '1) begin
            r_starve_cnt <= r_starve_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_flit  <= '0;
        end else begin
            r_out_valid <= (w_sel != SEL_NONE);
            r_out_flit  <= w_sel_flit;
        end
    end

    // Mode FSM: state register, next-state, outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= HRS_NORMAL;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            HRS_NORMAL: begin
                if (w_defl)                          w_state_nxt = HRS_DRAIN;
                else if (w_starving && !w_inj_starve) w_state_nxt = HRS_STARVE;
            end
            HRS_STARVE: begin
                if (w_defl)                              w_state_nxt = HRS_DRAIN;
                else if (w_inj_starve || !bus.inj_valid) w_state_nxt = HRS_NORMAL;
            end
            HRS_DRAIN: begin
                if (w_starving && !w_defl && !w_inj_starve) w_state_nxt = HRS_STARVE;
                else if (w_empty && !w_defl)                w_state_nxt = HRS_NORMAL;
            end
            default: w_state_nxt = HRS_NORMAL;
        endcase
    end

    always_comb begin
        w_drain_pending = 1'b0;
        if (r_state == HRS_DRAIN) w_drain_pending = !w_empty;
    end

`ifdef HRING_SCHED_STATS_EN
    logic [STAT_W-1:0] r_stat_defl;
    logic [STAT_W-1:0] r_stat_inj;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stat_defl <= '0;
            r_stat_inj  <= '0;
        end else begin
            if (w_defl)      r_stat_defl <= sat_inc(r_stat_defl);
            if (w_inj_ready) r_stat_inj  <= sat_inc(r_stat_inj);
        end
    end

    assign o_stat_defl = r_stat_defl;
    assign o_stat_inj  = r_stat_inj;
`else
    assign o_stat_defl = '0;
    assign o_stat_inj  = '0;
`endif

endmodule

// File: tb/tb_hring_boundary_sched.sv
// Randomized self-checking bench for hring_boundary_sched against a queue-based slot model.
module tb_hring_boundary_sched;
    import hring_boundary_sched_pkg::*;

    localparam int BUF_DEPTH  = 4;
    localparam int STARVE_MAX = 8;
    localparam int CNT_MAX    = 15;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  buf_count;
    logic [15:0] stat_defl;
    logic [15:0] stat_inj;

    int errors = 0;
    int checks = 0;

    flit_t mq[$];
    int    mcnt;
    bit    mvalid;
    flit_t mflit;
    int    mdefl;
    int    minj;
    bit    m_last_rdy;

    hring_boundary_sched_if bus ();

    hring_boundary_sched #(
        .BUF_DEPTH  (BUF_DEPTH),
        .STARVE_MAX (STARVE_MAX),
        .CNT_W      (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .o_buf_count (buf_count),
        .o_stat_defl (stat_defl),
        .o_stat_inj  (stat_inj)
    );

    always #5 clk = ~clk;

    // Push and pop in the same cycle must never happen.
    always @(posedge clk) begin
        if (!rst) begin
            assert (!(dut.w_push && dut.w_pop))
            else begin
                $display("FAIL push_pop_same_cycle: push=%0b pop=%0b required not both", dut.w_push, dut.w_pop);
                errors++;
            end
        end
    end

    function automatic flit_t rand_flit();
        logic [159:0] t;
        t = {$urandom, $urandom, $urandom, $urandom, $urandom};
        return t[CONTROL_W-1:0];
    endfunction

    function automatic int exp_stat(int v);
`ifdef HRING_SCHED_STATS_EN
        return (v > 65535) ? 65535 : v;
`else
        return 0 * v;
`endif
    endfunction

    task automatic model_clear();
        mq.delete();
        mcnt       = 0;
        mvalid     = 0;
        mflit      = '0;
        mdefl      = 0;
        minj       = 0;
        m_last_rdy = 0;
    endtask

    task automatic drive_idle();
        bus.ring_valid = 1'b0;
        bus.ring_flit  = '0;
        bus.inj_valid  = 1'b0;
        bus.inj_flit   = '0;
    endtask

    // One clock: predict from the slot rules, check inj_ready mid-cycle and registered outputs after the edge.
    task automatic cycle();
        bit    starving;
        bit    rdy;
        bit    nv;
        flit_t nf;
        @(negedge clk);
        starving = bus.inj_valid && (mcnt >= STARVE_MAX);
        nv  = 1;
        rdy = 0;
        nf  = mflit;
        if (starving && bus.ring_valid && mq.size() < BUF_DEPTH) begin
            mq.push_back(bus.ring_flit);
            nf = bus.inj_flit; rdy = 1; mdefl++;
        end else if (starving && !bus.ring_valid) begin
            nf = bus.inj_flit; rdy = 1;
        end else if (bus.ring_valid) begin
            nf = bus.ring_flit;
        end else if (mq.size() > 0) begin
            nf = mq.pop_front();
        end else if (bus.inj_valid) begin
            nf = bus.inj_flit; rdy = 1;
        end else begin
            nv = 0;
        end
        checks++;
        if (bus.inj_ready !== rdy) begin
            $display("FAIL inj_ready: got %0b required %0b (t=%0t)", bus.inj_ready, rdy, $time);
            errors++;
        end
        if (!bus.inj_valid || rdy) mcnt = 0;
        else if (mcnt < CNT_MAX)   mcnt = mcnt + 1;
        if (rdy) minj++;
        m_last_rdy = rdy;
        @(posedge clk);
        #1;
        mvalid = nv;
        if (nv) mflit = nf;
        checks++;
        if (bus.out_valid !== mvalid) begin
            $display("FAIL out_valid: got %0b required %0b (t=%0t)", bus.out_valid, mvalid, $time);
            errors++;
        end
        checks++;
        if (bus.out_flit !== mflit) begin
            $display("FAIL out_flit: got %h required %h (t=%0t)", bus.out_flit, mflit, $time);
            errors++;
        end
        checks++;
        if (buf_count !== 3'(mq.size())) begin
            $display("FAIL buf_count: got %0d required %0d (t=%0t)", buf_count, mq.size(), $time);
            errors++;
        end
        checks++;
        if (stat_defl !== 16'(exp_stat(mdefl)) || stat_inj !== 16'(exp_stat(minj))) begin
            $display("FAIL stats: got defl=%0d inj=%0d required defl=%0d inj=%0d",
                     stat_defl, stat_inj, exp_stat(mdefl), exp_stat(minj));
            errors++;
        end
    endtask

    task automatic do_reset();
        drive_idle();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_clear();
    endtask

    task automatic test_reset();
        drive_idle();
        bus.inj_valid = 1'b1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (bus.inj_ready !== 1'b0 || bus.out_valid !== 1'b0 || buf_count !== 3'd0 || bus.out_flit !== '0) begin
            $display("FAIL reset_state: got rdy=%0b ov=%0b cnt=%0d required 0 0 0 with flit 0",
                     bus.inj_ready, bus.out_valid, buf_count);
            errors++;
        end
        bus.inj_valid = 1'b0;
        rst = 1'b0;
        model_clear();
        repeat (10) cycle();
    endtask

    task automatic test_single_inj();
        flit_t v;
        v = 144'h0123456789abcdef0123456789abcdef;
        bus.inj_valid = 1'b1;
        bus.inj_flit  = v;
        cycle();
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_flit !== v) begin
            $display("FAIL single_inj: got ov=%0b flit=%h required 1 %h", bus.out_valid, bus.out_flit, v);
            errors++;
        end
        bus.inj_valid = 1'b0;
        cycle();
    endtask

    task automatic test_starve();
        int first_rdy;
        do_reset();
        first_rdy = -1;
        bus.ring_valid = 1'b1;
        bus.inj_valid  = 1'b1;
        bus.inj_flit   = rand_flit();
        for (int i = 1; i <= 60; i++) begin
            bus.ring_flit = rand_flit();
            cycle();
            if (m_last_rdy) begin
                if (first_rdy < 0) first_rdy = i;
                bus.inj_flit = rand_flit();
            end
        end
        checks++;
        if (first_rdy != 9) begin
            $display("FAIL starve_first_ready: got cycle %0d required 9", first_rdy);
            errors++;
        end
        checks++;
        if (buf_count !== 3'd4) begin
            $display("FAIL starve_buf_full: got %0d required 4", buf_count);
            errors++;
        end
        bus.ring_valid = 1'b0;
        bus.inj_valid  = 1'b0;
        repeat (6) cycle();
    endtask

    task automatic test_drain();
        int rdy_at;
        do_reset();
        bus.ring_valid = 1'b1;
        bus.inj_valid  = 1'b1;
        bus.inj_flit   = rand_flit();
        for (int i = 0; i < 40 && mdefl < 3; i++) begin
            bus.ring_flit = rand_flit();
            cycle();
            if (m_last_rdy) bus.inj_flit = rand_flit();
        end
        bus.ring_valid = 1'b0;
        rdy_at = -1;
        for (int i = 1; i <= 6; i++) begin
            cycle();
            if (m_last_rdy && rdy_at < 0) rdy_at = i;
            if (m_last_rdy) bus.inj_valid = 1'b0;
        end
        checks++;
        if (rdy_at != 4) begin
            $display("FAIL drain_inj_ready: got cycle %0d required 4", rdy_at);
            errors++;
        end
    endtask

    task automatic test_random();
        int dens;
        do_reset();
        dens = 2;
        for (int i = 0; i < 400; i++) begin
            if (i % 50 == 0) dens = int'($urandom_range(0, 4));
            bus.ring_valid = (int'($urandom_range(0, 3)) < dens);
            bus.ring_flit  = rand_flit();
            if (!(bus.inj_valid && !m_last_rdy) || $urandom_range(0, 15) == 0) begin
                bus.inj_valid = 1'($urandom_range(0, 1));
                bus.inj_flit  = rand_flit();
            end
            cycle();
        end
        drive_idle();
        repeat (6) cycle();
    endtask

    task automatic test_reset_mid();
        do_reset();
        bus.ring_valid = 1'b1;
        bus.inj_valid  = 1'b1;
        bus.inj_flit   = rand_flit();
        for (int i = 0; i < 45; i++) begin
            bus.ring_flit = rand_flit();
            cycle();
            if (m_last_rdy) bus.inj_flit = rand_flit();
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || buf_count !== 3'd0 || bus.inj_ready !== 1'b0 ||
            stat_defl !== 16'd0 || stat_inj !== 16'd0) begin
            $display("FAIL reset_mid: got ov=%0b cnt=%0d rdy=%0b defl=%0d inj=%0d required all 0",
                     bus.out_valid, buf_count, bus.inj_ready, stat_defl, stat_inj);
            errors++;
        end
        drive_idle();
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_clear();
        repeat (4) cycle();
    endtask

    initial begin
        drive_idle();
        model_clear();
        test_reset();
        test_single_inj();
        test_starve();
        test_drain();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
